countdown_display: RTL and testbench
====================================

COUNTDOWN_DISPLAY -- requirements
Module: countdown_display

Interface
REQ-001 Parameter REFRESH_DIV, default 50000: clock cycles per digit scan slot, minimum 2.
REQ-002 Parameter BLINK_DIV, default 25000000: clock cycles per blink half-period, minimum 2.
REQ-003 clk  input  1  single system clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  asynchronous active-low reset; one clock, async active-low reset.
REQ-005 count  input  7  binary seconds remaining from the countdown timer, 0..127.
REQ-006 seg  output  7  segment drive {g,f,e,d,c,b,a}, active-high.
REQ-007 an  output  2  digit enable, active-high; an[0] ones digit, an[1] tens digit.
REQ-008 bcd_tens  output  4  registered tens digit, 0..9.
REQ-009 bcd_ones  output  4  registered ones digit, 0..9.
REQ-010 busy  output  1  high while a binary-to-BCD conversion is in progress.

Function
REQ-011 Conversion FSM states: IDLE, SHIFT, DONE.
REQ-012 IDLE: if pending flag set or count != last_count, capture min(count,99) into shift register, store count into last_count, clear pending, go SHIFT, busy=1 from that edge.
REQ-013 SHIFT: exactly 7 cycles of double-dabble (add 3 to any BCD nibble >=5, then shift left 1), then DONE.
REQ-014 DONE: load bcd_tens/bcd_ones from shift result, busy=0, return IDLE, all on the same edge.
REQ-015 Latency: count change sampled at edge k -> bcd outputs valid and busy=0 after edge k+8.
REQ-016 count changes while busy are ignored until IDLE; IDLE then compares against last_count, so the latest value always converts; intermediate values may be skipped.
REQ-017 count 100..127 saturates to 99 before conversion.
REQ-018 Scan counter counts 0..REFRESH_DIV-1, wraps; digit select toggles on wrap; ones slot first after reset.
REQ-019 Ones slot: an=2'b01, seg=encode(bcd_ones).
REQ-020 Tens slot: an=2'b10, seg=encode(bcd_tens); if bcd_tens==0, leading-zero blank: an=2'b00, seg=7'h00.
REQ-021 Encoding 0..9: 3F,06,5B,4F,66,6D,7D,07,7F,6F; any other nibble -> 7'h00.
REQ-022 Blink counter counts 0..BLINK_DIV-1, wraps; blink phase toggles on wrap, phase on after reset.
REQ-023 When displayed value is 1..10 and blink phase off: an=2'b00, seg=7'h00; otherwise per REQ-019/020.
REQ-024 Displayed value 0: steady "0" on ones digit, no blink, tens blanked.
REQ-025 seg and an are registered (one cycle after slot/phase/BCD change).
REQ-026 Scan and blink counters run continuously, independent of busy.

Reset
REQ-027 rst_n low asynchronously forces: state=IDLE, busy=0, bcd_tens=0, bcd_ones=0, last_count=0, pending=1, scan/blink counters 0, digit select=ones, blink phase on, seg=7'h00, an=2'b00.
REQ-028 Reset asserted mid-conversion aborts it; partial results never reach bcd outputs.
REQ-029 After release, pending forces one conversion of current count regardless of last_count.

Verification (REFRESH_DIV=4, BLINK_DIV=16)
REQ-030 Reset release with count=60 -> busy high 8 cycles, then bcd_tens=6, bcd_ones=0; ones slot seg=3F an=01, tens slot seg=7D an=10.
REQ-031 count=7 steady -> tens slot an=00 seg=00; ones seg=07 alternating on/off every 16 cycles.
REQ-032 count=0 -> ones seg=3F steady across 64 cycles; tens slot blank; no blink gaps.
REQ-033 count=120 -> bcd 9/9, seg 6F on both digits, no blink.
REQ-034 count 45 -> 44 at edge k, then 43 at k+3 -> bcd=4/4 after k+8, second conversion starts k+9, bcd=4/3 after k+17.
REQ-035 rst_n low at SHIFT cycle 4 converting 59 -> bcd outputs 0/0 immediately, busy=0; after release reconverts current count.

Source files
------------

// File: rtl/countdown_display.sv
// Two-digit seven-segment countdown display: saturating binary-to-BCD conversion
// (double dabble), multiplexed digit scan, leading-zero blanking and a low-count blink.
module countdown_display #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] count,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       busy
);

    localparam int unsigned SCAN_W  = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam int unsigned SR_W    = 15;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(REFRESH_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [1:0]         state_q, state_d;
    logic               busy_q, busy_d;
    logic [3:0]         tens_q, tens_d;
    logic [3:0]         ones_q, ones_d;
    logic [6:0]         last_q, last_d;
    logic               pending_q, pending_d;
    logic [SR_W-1:0]    sr_q, sr_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [SCAN_W-1:0]  scan_q, scan_d;
    logic               sel_q, sel_d;
    logic [BLINK_W-1:0] blink_q, blink_d;
    logic               phase_q, phase_d;
    logic [6:0]         seg_q, seg_d;
    logic [1:0]         an_q, an_d;

    logic [6:0]      count_sat;
    logic [SR_W-1:0] sr_adj;
    logic            blink_range;

    function automatic logic [6:0] encode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'h3F;
            4'd1:    pattern = 7'h06;
            4'd2:    pattern = 7'h5B;
            4'd3:    pattern = 7'h4F;
            4'd4:    pattern = 7'h66;
            4'd5:    pattern = 7'h6D;
            4'd6:    pattern = 7'h7D;
            4'd7:    pattern = 7'h07;
            4'd8:    pattern = 7'h7F;
            4'd9:    pattern = 7'h6F;
            default: pattern = 7'h00;
        endcase
        return pattern;
    endfunction

    // One double-dabble step: correct each BCD nibble before the shift.
    always_comb begin
        sr_adj = sr_q;
        if (sr_q[10:7] >= 4'd5) begin
            sr_adj[10:7] = sr_q[10:7] + 4'd3;
        end
        if (sr_q[14:11] >= 4'd5) begin
            sr_adj[14:11] = sr_q[14:11] + 4'd3;
        end
        count_sat = (count > 7'd99) ? 7'd99 : count;
    end

    // Conversion FSM next state.
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        tens_d    = tens_q;
        ones_d    = ones_q;
        last_d    = last_q;
        pending_d = pending_q;
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (pending_q || (count != last_q)) begin
                    sr_d      = {8'd0, count_sat};
                    last_d    = count;
                    pending_d = 1'b0;
                    bit_cnt_d = 3'd0;
                    busy_d    = 1'b1;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                sr_d      = {sr_adj[SR_W-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd6) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                tens_d  = sr_q[14:11];
                ones_d  = sr_q[10:7];
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Free-running scan and blink timebases.
    always_comb begin
        scan_d  = scan_q + SCAN_W'(1);
        sel_d   = sel_q;
        blink_d = blink_q + BLINK_W'(1);
        phase_d = phase_q;
        if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            sel_d  = ~sel_q;
        end
        if (blink_q == BLINK_LAST) begin
            blink_d = '0;
            phase_d = ~phase_q;
        end
    end

    // Display values 1..10 blink; 0 stays lit as a steady ones digit.
    always_comb begin
        blink_range = ((tens_q == 4'd0) && (ones_q != 4'd0)) ||
                      ((tens_q == 4'd1) && (ones_q == 4'd0));
        seg_d = 7'h00;
        an_d  = 2'b00;
        if (blink_range && !phase_q) begin
            seg_d = 7'h00;
            an_d  = 2'b00;
        end else if (!sel_q) begin
            seg_d = encode(ones_q);
            an_d  = 2'b01;
        end else if (tens_q != 4'd0) begin
            seg_d = encode(tens_q);
            an_d  = 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            tens_q    <= 4'd0;
            ones_q    <= 4'd0;
            last_q    <= 7'd0;
            pending_q <= 1'b1;
            sr_q      <= '0;
            bit_cnt_q <= 3'd0;
            scan_q    <= '0;
            sel_q     <= 1'b0;
            blink_q   <= '0;
            phase_q   <= 1'b1;
            seg_q     <= 7'h00;
            an_q      <= 2'b00;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            last_q    <= last_d;
            pending_q <= pending_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            scan_q    <= scan_d;
            sel_q     <= sel_d;
            blink_q   <= blink_d;
            phase_q   <= phase_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign seg      = seg_q;
    assign an       = an_q;
    assign bcd_tens = tens_q;
    assign bcd_ones = ones_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_countdown_display.sv
// Directed bench for countdown_display with REFRESH_DIV=4, BLINK_DIV=16.
module tb_countdown_display;

    logic       clk;
    logic       rst_n;
    logic [6:0] count;
    logic [6:0] seg;
    logic [1:0] an;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int n        = 0;

    countdown_display #(
        .REFRESH_DIV(4),
        .BLINK_DIV  (16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .count   (count),
        .seg     (seg),
        .an      (an),
        .bcd_tens(bcd_tens),
        .bcd_ones(bcd_ones),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clock edges since the last reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else        n <= n + 1;
    end

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] t [10];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return t[d];
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare seg/an each cycle against the expected scan/blink pattern for a stable value.
    task automatic disp_window(input int cycles, input int tens, input int ones);
        int m;
        bit sel;
        bit phase;
        bit blinky;
        int e_seg;
        int e_an;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            m      = n - 1;
            sel    = ((m / 4) % 2) == 1;
            phase  = ((m / 16) % 2) == 0;
            blinky = (tens * 10 + ones >= 1) && (tens * 10 + ones <= 10);
            if (blinky && !phase) begin
                e_seg = 0; e_an = 0;
            end else if (!sel) begin
                e_seg = int'(seg_of(ones)); e_an = 1;
            end else if (tens == 0) begin
                e_seg = 0; e_an = 0;
            end else begin
                e_seg = int'(seg_of(tens)); e_an = 2;
            end
            chk("seg", int'(seg), e_seg);
            chk("an", int'(an), e_an);
        end
    endtask

    task automatic convert_to(input logic [6:0] v, input int tens, input int ones);
        @(negedge clk);
        count = v;
        repeat (10) @(posedge clk);
        #1;
        chk("conv_busy", int'(busy), 0);
        chk("conv_tens", int'(bcd_tens), tens);
        chk("conv_ones", int'(bcd_ones), ones);
    endtask

    initial begin
        rst_n = 1'b0;
        count = 7'd60;
        #12;
        chk("rst_seg", int'(seg), 0);
        chk("rst_an", int'(an), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_tens", int'(bcd_tens), 0);
        chk("rst_ones", int'(bcd_ones), 0);

        // Release with 60: eight busy cycles, then 6/0.
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            chk("busy60", int'(busy), 1);
        end
        @(posedge clk); #1;
        chk("busy60_end", int'(busy), 0);
        chk("tens60", int'(bcd_tens), 6);
        chk("ones60", int'(bcd_ones), 0);
        disp_window(40, 6, 0);

        convert_to(7'd7, 0, 7);
        disp_window(64, 0, 7);

        convert_to(7'd0, 0, 0);
        disp_window(64, 0, 0);

        convert_to(7'd120, 9, 9);
        disp_window(32, 9, 9);

        convert_to(7'd10, 1, 0);
        disp_window(48, 1, 0);

        // 45 -> 44 at edge k, 43 at k+3 while busy.
        convert_to(7'd45, 4, 5);
        @(negedge clk);
        count = 7'd44;
        @(posedge clk); #1;
        chk("k_busy", int'(busy), 1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        count = 7'd43;
        repeat (6) @(posedge clk);
        #1;
        chk("k8_busy", int'(busy), 0);
        chk("k8_tens", int'(bcd_tens), 4);
        chk("k8_ones", int'(bcd_ones), 4);
        @(posedge clk); #1;
        chk("k9_busy", int'(busy), 1);
        repeat (7) @(posedge clk);
        #1;
        chk("k16_busy", int'(busy), 1);
        chk("k16_ones", int'(bcd_ones), 4);
        @(posedge clk); #1;
        chk("k17_busy", int'(busy), 0);
        chk("k17_tens", int'(bcd_tens), 4);
        chk("k17_ones", int'(bcd_ones), 3);

        // Reset in the middle of converting 59.
        @(negedge clk);
        count = 7'd59;
        @(posedge clk); #1;
        chk("r59_busy", int'(busy), 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_tens", int'(bcd_tens), 0);
        chk("abort_ones", int'(bcd_ones), 0);
        chk("abort_seg", int'(seg), 0);
        chk("abort_an", int'(an), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            chk("busy59", int'(busy), 1);
        end
        @(posedge clk); #1;
        chk("busy59_end", int'(busy), 0);
        chk("tens59", int'(bcd_tens), 5);
        chk("ones59", int'(bcd_ones), 9);

        // Pending flag converts even when count equals the reset last_count.
        @(negedge clk);
        rst_n = 1'b0;
        count = 7'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("pend_busy", int'(busy), 1);
        repeat (8) @(posedge clk);
        #1;
        chk("pend_done", int'(busy), 0);
        chk("pend_ones", int'(bcd_ones), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
